// File: rtl/mem_stage_access_unit_if.sv
// Data-memory request/response bundle for the MEM stage.
// master issues req/we/addr/wdata/be; slave answers with ready/rdata.
interface mem_stage_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM stage: variable-latency data access, lane formatting, branch, MEM/WB.
// Optional misaligned-access trap: define MEM_ALIGN_CHECK_EN.
module mem_stage_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic        branch_in,
  input  logic        zero_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  writebackDestination_in,
  input  logic [1:0]  load_mode_in,
  mem_stage_access_unit_if.master dmem,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        mem_timeout,
  output logic        misalign_fault,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] readData_out,
  output logic [31:0] aluResult_out,
  output logic [4:0]  writebackDestination_out
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  dest;
  } mem_wb_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  mem_wb_t     wb_q, wb_d;

  logic        access;
  logic        misal;
  logic        stall_c;
  logic [1:0]  a;
  logic        w_mode;
  logic        h_mode;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  logic [31:0] rdata_fmt;

  assign access = MemRead_in | MemWrite_in;
  assign a      = aluResult_in[1:0];
  assign w_mode = (load_mode_in == 2'b00);
  assign h_mode = (load_mode_in == 2'b01);

  assign branch_taken  = branch_in & zero_in;
  assign branch_target = pc_in;

  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = rt_in;
    unique case (1'b1)
      w_mode: begin
        be_fmt    = 4'b1111;
        wdata_fmt = rt_in;
      end
      h_mode: begin
        be_fmt    = a[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{rt_in[15:0]}};
      end
      default: begin
        be_fmt    = 4'b0001 << a;
        wdata_fmt = {4{rt_in[7:0]}};
      end
    endcase
  end

  assign lane_h = off_q[1] ? dmem.mem_rdata[31:16]
                           : dmem.mem_rdata[15:0];
  assign lane_b = dmem.mem_rdata[{off_q, 3'b000} +: 8];

  always_comb begin
    rdata_fmt = dmem.mem_rdata;
    unique case (1'b1)
      mode_q == 2'b00: rdata_fmt = dmem.mem_rdata;
      mode_q == 2'b01: rdata_fmt = {{16{lane_h[15]}}, lane_h};
      mode_q == 2'b10: rdata_fmt = {{24{lane_b[7]}}, lane_b};
      default:         rdata_fmt = {24'b0, lane_b};
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_q;

  assign misal = access &
    ((w_mode & (a != 2'b00)) | (h_mode & a[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_q == IDLE) & misal;
  end

  assign misalign_fault = fault_q;
`else
  assign misal          = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    mode_d  = mode_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    stall_c = 1'b0;
    // default MEM/WB load is a bubble
    wb_d.reg_write  = 1'b0;
    wb_d.mem_to_reg = 1'b0;
    wb_d.read_data  = '0;
    wb_d.alu_result = aluResult_in;
    wb_d.dest       = writebackDestination_in;
    unique case (state_q)
      IDLE: begin
        if (misal) begin
          wb_d.mem_to_reg = MemToReg_in;
        end else if (access) begin
          stall_c = 1'b1;
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = MemWrite_in;
          addr_d  = {aluResult_in[31:2], 2'b00};
          wdata_d = wdata_fmt;
          be_d    = be_fmt;
          off_d   = a;
          mode_d  = load_mode_in;
          cnt_d   = '0;
        end else begin
          wb_d.reg_write  = RegWrite_in;
          wb_d.mem_to_reg = MemToReg_in;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (dmem.mem_ready) begin
          req_d   = 1'b0;
          data_d  = we_q ? 32'd0 : rdata_fmt;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          data_d  = 32'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        wb_d.reg_write  = RegWrite_in & ~tmo_q;
        wb_d.mem_to_reg = MemToReg_in;
        wb_d.read_data  = data_q;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      wb_q    <= wb_d;
    end
  end

  // stall must fall with reset even while the inputs still request
  assign stall = rst_n & stall_c;

  assign dmem.mem_req   = req_q;
  assign dmem.mem_we    = we_q;
  assign dmem.mem_addr  = addr_q;
  assign dmem.mem_wdata = wdata_q;
  assign dmem.mem_be    = be_q;

  assign mem_timeout              = tmo_q;
  assign RegWrite_out             = wb_q.reg_write;
  assign MemToReg_out             = wb_q.mem_to_reg;
  assign readData_out             = wb_q.read_data;
  assign aluResult_out            = wb_q.alu_result;
  assign writebackDestination_out = wb_q.dest;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: instruction-level model + per-cycle compare.
// Build with MEM_ALIGN_CHECK_EN to exercise the misalignment trap.
module tb_mem_stage_access_unit;

  localparam int TMO = 16;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in;
  logic        branch_in, zero_in;
  logic [31:0] pc_in, aluResult_in, rt_in;
  logic [4:0]  writebackDestination_in;
  logic [1:0]  load_mode_in;
  logic        stall, branch_taken, mem_timeout, misalign_fault;
  logic [31:0] branch_target;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] readData_out, aluResult_out;
  logic [4:0]  writebackDestination_out;

  mem_stage_access_unit_if dmem();

  mem_stage_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RegWrite_in(RegWrite_in),
    .MemWrite_in(MemWrite_in),
    .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in),
    .branch_in(branch_in),
    .zero_in(zero_in),
    .pc_in(pc_in),
    .aluResult_in(aluResult_in),
    .rt_in(rt_in),
    .writebackDestination_in(writebackDestination_in),
    .load_mode_in(load_mode_in),
    .dmem(dmem),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .mem_timeout(mem_timeout),
    .misalign_fault(misalign_fault),
    .RegWrite_out(RegWrite_out),
    .MemToReg_out(MemToReg_out),
    .readData_out(readData_out),
    .aluResult_out(aluResult_out),
    .writebackDestination_out(writebackDestination_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  int tmo_cnt = 0;
  int flt_cnt = 0;
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_we, e_tmo, e_fault;
  logic        e_bt, e_full, e_rw, e_m2r;
  logic [31:0] e_addr, e_wdata, e_tgt, e_rdata, e_alu;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  logic [31:0] last_addr, last_wd;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_mis(input logic [1:0] mode,
                                 input logic [1:0] a);
    return ALIGN && ((mode == 2'd0 && a != 2'd0) ||
                     (mode == 2'd1 && a[0]));
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] mode,
                                      input logic [1:0] a);
    if (mode == 2'd0) return 4'hF;
    if (mode == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'(1 << a);
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] mode,
                                       input logic [31:0] rt);
    if (mode == 2'd0) return rt;
    if (mode == 2'd1) return {16'd0, rt[15:0]} * 32'h0001_0001;
    return {24'd0, rt[7:0]} * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] mode,
                                         input logic [1:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    if (mode == 2'd0) return w;
    if (mode == 2'd1) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      return v[15] ? (v | 32'hFFFF_0000) : v;
    end
    v = (w >> (8 * int'(a))) & 32'hFF;
    if (mode == 2'd2 && v[7]) return v | 32'hFFFF_FF00;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("mem_req", {31'd0, dmem.mem_req}, {31'd0, e_req});
      if (e_req) begin
        chk("mem_we", {31'd0, dmem.mem_we}, {31'd0, e_we});
        chk("mem_addr", dmem.mem_addr, e_addr);
        if (e_we) begin
          chk("mem_be", {28'd0, dmem.mem_be}, {28'd0, e_be});
          chk("mem_wdata", dmem.mem_wdata, e_wdata);
        end
      end
      chk("branch_taken", {31'd0, branch_taken}, {31'd0, e_bt});
      chk("branch_target", branch_target, e_tgt);
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, e_tmo});
      chk("misalign", {31'd0, misalign_fault}, {31'd0, e_fault});
      chk("RegWrite_out", {31'd0, RegWrite_out}, {31'd0, e_rw});
      chk("MemToReg_out", {31'd0, MemToReg_out}, {31'd0, e_m2r});
      if (e_full) begin
        chk("readData_out", readData_out, e_rdata);
        chk("aluResult_out", aluResult_out, e_alu);
        chk("wb_dest", {27'd0, writebackDestination_out},
            {27'd0, e_rd});
      end
      if (stall) stall_cnt++;
      if (mem_timeout) tmo_cnt++;
      if (misalign_fault) flt_cnt++;
      if (dmem.mem_req) begin
        req_cnt++;
        last_addr = dmem.mem_addr;
        last_wd   = dmem.mem_wdata;
        last_be   = dmem.mem_be;
        last_we   = dmem.mem_we;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic rw, input logic m2r,
                        input logic [31:0] rd_data,
                        input logic [31:0] alu, input logic [4:0] dst,
                        input logic full);
    e_rw = rw; e_m2r = m2r; e_rdata = rd_data;
    e_alu = alu; e_rd = dst; e_full = full;
  endtask

  task automatic set_br(input logic b, input logic z,
                        input logic [31:0] pc);
    branch_in = b; zero_in = z; pc_in = pc;
    e_bt = b & z; e_tgt = pc;
  endtask

  // One EX/MEM instruction held until the unit releases stall.
  // waits < 0 means the memory never answers.
  task automatic run(input logic rw, input logic mr, input logic mw,
                     input logic m2r, input logic [31:0] alu,
                     input logic [31:0] rt, input logic [4:0] rd,
                     input logic [1:0] mode, input int waits,
                     input logic [31:0] rdata);
    logic [1:0]  a;
    logic        mis, tmo, fin;
    logic [31:0] data;
    int          n;
    a = alu[1:0];
    RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw;
    MemToReg_in = m2r; aluResult_in = alu; rt_in = rt;
    writebackDestination_in = rd; load_mode_in = mode;
    dmem.mem_ready = 1'b0;
    dmem.mem_rdata = 32'hBAD0_0BAD;
    mis = (mr | mw) && m_mis(mode, a);
    if (!(mr | mw) || mis) begin
      e_stall = 1'b0; e_req = 1'b0;
      tick();
      e_fault = mis; e_tmo = 1'b0;
      set_wb(rw & ~mis, m2r, 32'd0, alu, rd, 1'b1);
    end else begin
      e_stall = 1'b1; e_req = 1'b0;
      tick();
      e_fault = 1'b0; e_tmo = 1'b0;
      set_wb(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      e_req = 1'b1; e_we = mw;
      e_addr = {alu[31:2], 2'b00};
      e_be = m_be(mode, a); e_wdata = m_wd(mode, rt);
      n = 0; tmo = 1'b0; fin = 1'b0;
      while (!fin) begin
        if (waits >= 0 && n == waits) begin
          dmem.mem_ready = 1'b1;
          dmem.mem_rdata = rdata;
          tick();
          dmem.mem_ready = 1'b0;
          dmem.mem_rdata = 32'hBAD0_0BAD;
          fin = 1'b1;
        end else begin
          tick();
          n++;
          if (n == TMO) begin
            tmo = 1'b1;
            fin = 1'b1;
          end
        end
      end
      e_req = 1'b0; e_stall = 1'b0; e_tmo = tmo;
      data = (tmo || mw) ? 32'd0 : m_load(mode, a, rdata);
      tick();
      e_tmo = 1'b0;
      set_wb(rw & ~tmo, m2r, data, alu, rd, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; MemToReg_in = 0;
    aluResult_in = 0; rt_in = 0; writebackDestination_in = 0;
    load_mode_in = 0;
    dmem.mem_ready = 1'b0; dmem.mem_rdata = 32'd0;
    set_br(1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem.mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rst_readdata", readData_out, 32'd0);
    rst_n = 1'b1;
    tick();
    e_stall = 0; e_req = 0; e_tmo = 0; e_fault = 0;
    set_wb(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk_en = 1'b1;

    run(1, 0, 0, 0, 32'h0000_1234, 0, 5'd5, 2'd0, 0, 0);
    chk("alu_passthru", aluResult_out, 32'h0000_1234);

    stall_cnt = 0;
    run(1, 1, 0, 1, 32'h0000_1003, 0, 5'd7, 2'b10, 0, 32'h80FF_1234);
    chk("lb_addr", last_addr, 32'h0000_1000);
    chk("lb_stall_cycles", stall_cnt, 2);
    chk("lb_data", readData_out, 32'hFFFF_FF80);
    chk("lb_regwrite", {31'd0, RegWrite_out}, 32'd1);

    run(0, 0, 1, 0, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 2'b01, 0, 0);
    chk("sh_be", {28'd0, last_be}, 32'hC);
    chk("sh_wdata", last_wd, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, last_we}, 32'd1);

    run(0, 0, 1, 0, 32'h0000_3001, 32'h1234_5678, 5'd0, 2'b11, 2, 0);
    chk("sb_be", {28'd0, last_be}, 32'h2);
    chk("sb_wdata", last_wd, 32'h7878_7878);

    stall_cnt = 0;
    run(1, 1, 0, 1, 32'h0000_4002, 0, 5'd9, 2'b01, 3, 32'h8001_7FFF);
    chk("lh_stall_cycles", stall_cnt, 5);
    chk("lh_data", readData_out, 32'hFFFF_8001);

    run(1, 1, 0, 1, 32'h0000_5000, 0, 5'd10, 2'b00, 1, 32'hDEAD_BEEF);
    run(1, 1, 0, 1, 32'h0000_6002, 0, 5'd11, 2'b11, 0, 32'h00A5_0000);
    chk("lbu_data", readData_out, 32'h0000_00A5);

    run(0, 0, 1, 0, 32'h0000_7000, 32'hCAFE_BABE, 5'd0, 2'b00, 0, 0);
    chk("sw_be", {28'd0, last_be}, 32'hF);

    run(1, 1, 1, 1, 32'h0000_7104, 32'h1122_3344, 5'd3, 2'b00, 0,
        32'h5555_5555);
    chk("rw_both_we", {31'd0, last_we}, 32'd1);
    chk("rw_both_data", readData_out, 32'd0);

    tmo_cnt = 0; req_cnt = 0; stall_cnt = 0;
    run(1, 1, 0, 1, 32'h0000_9000, 0, 5'd12, 2'b00, -1, 0);
    chk("tmo_pulses", tmo_cnt, 1);
    chk("tmo_req_cycles", req_cnt, TMO);
    chk("tmo_stall_cycles", stall_cnt, TMO + 1);
    chk("tmo_regwrite", {31'd0, RegWrite_out}, 32'd0);

    set_br(1'b1, 1'b1, 32'h0000_0040);
    #1;
    chk("br_taken", {31'd0, branch_taken}, 32'd1);
    chk("br_target", branch_target, 32'h0000_0040);
    run(1, 1, 0, 1, 32'h0000_A000, 0, 5'd13, 2'b00, 1, 32'h0BAD_F00D);
    set_br(1'b1, 1'b0, 32'h0000_0080);
    run(1, 0, 0, 0, 32'h0000_0077, 0, 5'd14, 2'b00, 0, 0);
    set_br(1'b0, 1'b0, 32'd0);

    flt_cnt = 0; req_cnt = 0;
    run(1, 1, 0, 1, 32'h0000_1002, 0, 5'd4, 2'b00, 0, 32'hA1B2_C3D4);
    if (ALIGN) chk("mis_regwrite", {31'd0, RegWrite_out}, 32'd0);
    else       chk("mis_data", readData_out, 32'hA1B2_C3D4);
    run(1, 0, 0, 0, 32'h0000_0001, 0, 5'd1, 2'b00, 0, 0);
    chk("mis_fault_pulses", flt_cnt, ALIGN ? 1 : 0);
    chk("mis_req_cycles", req_cnt, ALIGN ? 0 : 1);

    chk_en = 1'b0;
    RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 0; MemToReg_in = 1;
    aluResult_in = 32'h0000_8000; writebackDestination_in = 5'd21;
    load_mode_in = 2'b00;
    tick();
    tick();
    chk("pre_rst_req", {31'd0, dmem.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dmem.mem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_alu", aluResult_out, 32'd0);
    chk("mid_rst_dest", {27'd0, writebackDestination_out}, 32'd0);
    RegWrite_in = 0; MemRead_in = 0; MemToReg_in = 0;
    aluResult_in = 0; writebackDestination_in = 0;
    dmem.mem_ready = 1'b1; dmem.mem_rdata = 32'h1234_5678;
    tick();
    rst_n = 1'b1;
    tick();
    dmem.mem_ready = 1'b0;
    chk("late_ready_req", {31'd0, dmem.mem_req}, 32'd0);
    chk("late_ready_stall", {31'd0, stall}, 32'd0);
    chk("late_ready_data", readData_out, 32'd0);
    e_stall = 0; e_req = 0; e_tmo = 0; e_fault = 0;
    set_wb(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk_en = 1'b1;
    run(1, 1, 0, 1, 32'h0000_B001, 0, 5'd2, 2'b10, 0, 32'h0000_7F00);
    chk("post_rst_data", readData_out, 32'h0000_007F);
    run(0, 0, 0, 0, 32'd0, 0, 5'd0, 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Drives data memory through a req/ready handshake with variable latency and stalls upstream stages while an access is outstanding.
- Formats store byte-enables and sign/zero-extends load data by load mode.
- Resolves branches and registers the MEM/WB fields.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles before the access is abandoned and mem_timeout pulses.

Ports:
- clk in 1: rising-edge clock.
- rst_n in 1: asynchronous active-low reset.
- RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, branch_in, zero_in in 1 each: EX/MEM control fields.
- pc_in in 32: branch target from EX/MEM.
- aluResult_in in 32: memory address / ALU result.
- rt_in in 32: store data.
- writebackDestination_in in 5: destination register.
- load_mode_in in 2: access width. 00 word, 01 half signed, 10 byte signed, 11 byte unsigned; stores use the width only.
- mem_req out 1: access request.
- mem_we out 1: 1 means write.
- mem_addr out 32: {aluResult[31:2],2'b00}.
- mem_wdata out 32: lane-replicated store data.
- mem_be out 4: byte enables.
- mem_ready in 1: memory completes the access in this cycle.
- mem_rdata in 32: read word, valid when mem_ready=1.
- stall out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- branch_taken out 1: combinational branch_in & zero_in.
- branch_target out 32: combinational pc_in.
- mem_timeout out 1: one-cycle pulse.
- misalign_fault out 1: see Optional Feature.
- RegWrite_out, MemToReg_out out 1 each: MEM/WB control fields.
- readData_out out 32: formatted load data.
- aluResult_out out 32: MEM/WB ALU result.
- writebackDestination_out out 5: MEM/WB destination register.

Behaviour:
- Reset: all registered outputs 0, FSM=IDLE, timeout counter 0. mem_req drops immediately. A memory response arriving after reset is ignored.
- access = MemRead_in | MemWrite_in. If both are set, the access is a write.
- IDLE:
  - access=0: stall=0; MEM/WB outputs load from the inputs every edge; readData_out<=0.
  - access=1: stall=1. At the edge: FSM->ACCESS, mem_req<=1, and mem_we/mem_addr/mem_wdata/mem_be are latched. MEM/WB loads a bubble (RegWrite_out=0, MemToReg_out=0).
- ACCESS:
  - stall=1, mem_req=1, request fields held stable.
  - Edge with mem_ready=1: mem_req<=0, formatted read data captured (writes capture 0), FSM->DONE.
  - Each edge with mem_ready=0: counter+1. If the counter reaches TIMEOUT_CYCLES-1, then mem_req<=0, mem_timeout<=1 for one cycle, FSM->DONE with captured data 0.
  - MEM/WB loads a bubble on every edge.
- DONE:
  - stall=0. At the edge, MEM/WB loads the EX/MEM fields plus the captured data as readData_out; RegWrite_out is forced 0 after a timeout. FSM->IDLE, counter cleared.
- Latency: with zero-wait memory (mem_ready high in the first ACCESS cycle), a memory instruction occupies 3 cycles, 2 of them stalled. Each extra wait cycle adds 1 stall cycle.
- Stores, little-endian, a = aluResult_in[1:0]:
  - word: be=1111, wdata=rt.
  - half: be = a[1] ? 1100 : 0011, wdata={rt[15:0],rt[15:0]}.
  - byte: be = 0001<<a, wdata=4{rt[7:0]}.
- Loads:
  - word: rdata as is.
  - half: lane selected by a[1], sign-extended.
  - byte: lane selected by a, sign-extended (10) or zero-extended (11).
- Branch outputs are purely combinational and independent of the FSM. Upstream must hold the EX/MEM register while stall=1, so branch outputs stay stable through a stall.
- Back-to-back memory instructions: each starts from IDLE after DONE. No overlap; there is one outstanding request at most.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - A word access with a!=00, or a half access with a[0]=1, is misaligned.
  - A misaligned access skips ACCESS: no mem_req, stall=0, FSM stays IDLE.
  - MEM/WB loads with RegWrite_out=0; misalign_fault pulses 1 for one cycle, registered.
- Undefined: misalign_fault is tied 0. Word accesses ignore a; half accesses ignore a[0]; the access proceeds normally.

Test Plan:
- Reset mid-ACCESS: drop rst_n while mem_req=1 -> mem_req, stall and all outputs 0 immediately. A late mem_ready is ignored and FSM returns to IDLE.
- Load byte signed: aluResult=0x1003, mode 10, rdata=0x80FF_1234, zero-wait -> mem_addr=0x1000, stall high 2 cycles, readData_out=0xFFFF_FF80, RegWrite_out=1.
- Store half: aluResult=0x2002, rt=0x0000_ABCD, mode 01 -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1.
- Wait states: mem_ready delayed 3 cycles -> stall high 5 cycles. MEM/WB shows bubbles until DONE, then the single write-back.
- Timeout: mem_ready never asserted, TIMEOUT_CYCLES=16 -> mem_timeout pulses once after 16 ACCESS cycles, RegWrite_out=0, stall released.
- With MEM_ALIGN_CHECK_EN, word load at 0x1002 -> no mem_req, misalign_fault=1 for 1 cycle, stall=0, RegWrite_out=0.
- Branch: branch_in=1, zero_in=1, pc_in=0x40 -> branch_taken=1 and branch_target=0x40 in the same cycle.
